branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_pkg.sv | 47 ++++
 rtl/branch_ctrl_if.sv | 35 +++
 rtl/jump_lut.sv | 31 +++
 rtl/branch_ctrl.sv | 106 ++++++++++
 tb/tb_branch_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: FSM states,
// branch condition encodings, program base addresses and LUT geometry.
package branch_pkg;

    localparam int ADDR_W     = 10;
    localparam int LUT_DEPTH  = 16;
    localparam int LUT_IDX_W  = $clog2(LUT_DEPTH);
    localparam int PROG_W     = 2;
    localparam int CNT_W      = 8;

    localparam logic [ADDR_W-1:0] BASE_PROG0 = 10'd0;
    localparam logic [ADDR_W-1:0] BASE_PROG1 = 10'd256;
    localparam logic [ADDR_W-1:0] BASE_PROG2 = 10'd512;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'b00,
        COND_ZERO   = 2'b01,
        COND_NEG    = 2'b10,
        COND_NZ     = 2'b11
    } br_cond_e;

    // Program index 3 is never produced; it maps to program 0's base.
    function automatic logic [ADDR_W-1:0] prog_base(input logic [PROG_W-1:0] prog);
        case (prog)
            2'd1:    return BASE_PROG1;
            2'd2:    return BASE_PROG2;
            default: return BASE_PROG0;
        endcase
    endfunction

    function automatic logic cond_eval(input br_cond_e cond, input logic zero, input logic neg);
        case (cond)
            COND_ZERO: return zero;
            COND_NEG:  return neg;
            COND_NZ:   return !zero;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Bundle of decode, flag, LUT-programming and PC-control signals around branch_ctrl.
interface branch_ctrl_if;
    import branch_pkg::*;

    logic                 start;
    logic                 halt;
    logic                 br_req;
    logic [1:0]           br_cond;
    logic [LUT_IDX_W-1:0] br_idx;
    logic                 zero_flag;
    logic                 neg_flag;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic [ADDR_W-1:0]    lut_data;

    logic                 jen;
    logic [ADDR_W-1:0]    jump;
    logic                 busy;
    logic                 done;
    logic [PROG_W-1:0]    prog_num;
    logic [CNT_W-1:0]     taken_cnt;

    modport master (
        output start, halt, br_req, br_cond, br_idx, zero_flag, neg_flag,
               lut_we, lut_addr, lut_data,
        input  jen, jump, busy, done, prog_num, taken_cnt
    );

    modport slave (
        input  start, halt, br_req, br_cond, br_idx, zero_flag, neg_flag,
               lut_we, lut_addr, lut_data,
        output jen, jump, busy, done, prog_num, taken_cnt
    );

endinterface

// File: rtl/jump_lut.sv
// Branch target table: 16 x 10-bit registers, synchronous write,
// asynchronous read, asynchronous clear.
module jump_lut
    import branch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [LUT_IDX_W-1:0] waddr_i,
    input  logic [ADDR_W-1:0]    wdata_i,
    input  logic [LUT_IDX_W-1:0] raddr_i,
    output logic [ADDR_W-1:0]    rdata_o
);

    logic [ADDR_W-1:0] mem_q [LUT_DEPTH];

    // NOTE: this table is built from flops, not a RAM macro, because every
    // entry must clear on reset; do not reset real memories this way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: launches one of three programs, resolves conditional
// branches through a target LUT with zero latency, and counts taken branches.
module branch_ctrl
    import branch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    branch_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic                 start_q;
    logic [PROG_W-1:0]    prog_num_q, prog_num_d;
    logic [CNT_W-1:0]     taken_cnt_q, taken_cnt_d;

    logic                 start_rise;
    logic                 lut_wr_en;
    logic [ADDR_W-1:0]    lut_rdata;
    logic                 jen;
    logic [ADDR_W-1:0]    jump;

    assign start_rise = bus.start && !start_q;

    jump_lut u_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (lut_wr_en),
        .waddr_i (bus.lut_addr),
        .wdata_i (bus.lut_data),
        .raddr_i (bus.br_idx),
        .rdata_o (lut_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            prog_num_q  <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            prog_num_q  <= prog_num_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        jen       = 1'b0;
        jump      = '0;
        lut_wr_en = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                lut_wr_en = bus.lut_we;
                if (start_rise) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                jen     = 1'b1;
                jump    = prog_base(prog_num_q);
                state_d = S_RUN;
            end
            S_RUN: begin
                // Halt wins over a branch decoded in the same cycle.
                if (bus.halt) begin
                    state_d = S_DONE;
                end else if (bus.br_req &&
                             cond_eval(br_cond_e'(bus.br_cond), bus.zero_flag, bus.neg_flag)) begin
                    jen  = 1'b1;
                    jump = lut_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prog_num_d  = prog_num_q;
        taken_cnt_d = taken_cnt_q;
        if ((state_q == S_IDLE || state_q == S_DONE) && start_rise) begin
            taken_cnt_d = '0;
        end
        if (state_q == S_RUN) begin
            if (jen && taken_cnt_q != {CNT_W{1'b1}}) begin
                taken_cnt_d = taken_cnt_q + 1'b1;
            end
            if (bus.halt) begin
                prog_num_d = (prog_num_q == 2'd2) ? 2'd0 : prog_num_q + 2'd1;
            end
        end
    end

    assign bus.jen       = jen;
    assign bus.jump      = jump;
    assign bus.busy      = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.prog_num  = prog_num_q;
    assign bus.taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a vector table for branch resolution in RUN
// plus hand-written sequences for launch, halt, wrap, saturation and reset.
module tb_branch_ctrl;
    import branch_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       br_req;
        logic [1:0] cond;
        logic [3:0] idx;
        logic       zero;
        logic       neg;
        logic       exp_jen;
        logic [9:0] exp_jump;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.halt      = 1'b0;
        bus.br_req    = 1'b0;
        bus.br_cond   = 2'b00;
        bus.br_idx    = 4'd0;
        bus.zero_flag = 1'b0;
        bus.neg_flag  = 1'b0;
        bus.lut_we    = 1'b0;
        bus.lut_addr  = 4'd0;
        bus.lut_data  = 10'd0;
    endtask

    task automatic lut_write(input logic [3:0] addr, input logic [9:0] data);
        bus.lut_we   = 1'b1;
        bus.lut_addr = addr;
        bus.lut_data = data;
        tick();
        bus.lut_we   = 1'b0;
    endtask

    // Start pulse from IDLE/DONE; checks the LAUNCH cycle, leaves DUT in RUN.
    task automatic launch(input logic [9:0] exp_base, input logic [1:0] exp_prog);
        bus.start = 1'b1;
        tick();
        #1;
        check("launch_jen", bus.jen, 1);
        check("launch_jump", bus.jump, exp_base);
        check("launch_busy", bus.busy, 1);
        check("launch_prog", bus.prog_num, exp_prog);
        check("launch_taken_clr", bus.taken_cnt, 0);
        bus.start = 1'b0;
        tick();
        #1;
        check("run_busy", bus.busy, 1);
        check("run_idle_jen", bus.jen, 0);
    endtask

    // Halt together with an always-taken branch; checks DONE on the next edge.
    task automatic halt_prog(input logic [1:0] exp_prog);
        bus.halt    = 1'b1;
        bus.br_req  = 1'b1;
        bus.br_cond = 2'b00;
        #1;
        check("halt_jen", bus.jen, 0);
        check("halt_jump", bus.jump, 0);
        tick();
        bus.halt   = 1'b0;
        bus.br_req = 1'b0;
        #1;
        check("done_flag", bus.done, 1);
        check("done_busy", bus.busy, 0);
        check("done_prog", bus.prog_num, exp_prog);
    endtask

    initial begin
        int exp_taken;
        int launches;

        vecs[0] = '{1'b1, 2'b01, 4'd3,  1'b0, 1'b0, 1'b0, 10'd0};
        vecs[1] = '{1'b1, 2'b01, 4'd3,  1'b1, 1'b0, 1'b1, 10'd10};
        vecs[2] = '{1'b0, 2'b00, 4'd3,  1'b0, 1'b0, 1'b0, 10'd0};
        vecs[3] = '{1'b1, 2'b00, 4'd5,  1'b0, 1'b0, 1'b1, 10'd777};
        vecs[4] = '{1'b1, 2'b10, 4'd5,  1'b0, 1'b0, 1'b0, 10'd0};
        vecs[5] = '{1'b1, 2'b10, 4'd15, 1'b1, 1'b1, 1'b1, 10'd1023};
        vecs[6] = '{1'b1, 2'b11, 4'd15, 1'b1, 1'b0, 1'b0, 10'd0};
        vecs[7] = '{1'b1, 2'b11, 4'd5,  1'b0, 1'b1, 1'b1, 10'd777};
        vecs[8] = '{1'b1, 2'b11, 4'd7,  1'b0, 1'b0, 1'b1, 10'd0};

        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check("rst_jen", bus.jen, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_prog", bus.prog_num, 0);
        check("rst_taken", bus.taken_cnt, 0);
        #20;
        rst_n = 1'b1;
        tick();

        lut_write(4'd3, 10'd10);
        lut_write(4'd5, 10'd777);
        lut_write(4'd15, 10'd1023);
        bus.halt   = 1'b1;
        bus.br_req = 1'b1;
        #1;
        check("idle_ignores_br", bus.jen, 0);
        tick();
        check("idle_ignores_halt", bus.done, 0);
        idle_inputs();

        launch(10'd0, 2'd0);

        exp_taken = 0;
        foreach (vecs[i]) begin
            bus.br_req    = vecs[i].br_req;
            bus.br_cond   = vecs[i].cond;
            bus.br_idx    = vecs[i].idx;
            bus.zero_flag = vecs[i].zero;
            bus.neg_flag  = vecs[i].neg;
            #1;
            check($sformatf("vec%0d_jen", i), bus.jen, vecs[i].exp_jen);
            check($sformatf("vec%0d_jump", i), bus.jump, vecs[i].exp_jump);
            tick();
            if (vecs[i].exp_jen) exp_taken++;
            check($sformatf("vec%0d_taken", i), bus.taken_cnt, exp_taken);
        end
        idle_inputs();

        // A write while running must not reach the table.
        lut_write(4'd3, 10'd99);
        bus.br_req = 1'b1;
        bus.br_idx = 4'd3;
        #1;
        check("run_write_dropped", bus.jump, 10);
        bus.br_req = 1'b0;
        tick();

        halt_prog(2'd1);
        bus.br_req = 1'b1;
        #1;
        check("done_ignores_br", bus.jen, 0);
        bus.br_req = 1'b0;

        launch(10'd256, 2'd1);
        halt_prog(2'd2);
        launch(10'd512, 2'd2);
        halt_prog(2'd0);
        launch(10'd0, 2'd0);

        // Start held high for 5 cycles while running: no second launch.
        launches = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.jen) launches++;
            tick();
        end
        bus.start = 1'b0;
        check("held_start_no_relaunch", launches, 0);
        check("held_start_still_run", bus.busy, 1);

        // Taken counter saturation.
        bus.br_req  = 1'b1;
        bus.br_cond = 2'b00;
        for (int i = 0; i < 260; i++) tick();
        check("taken_saturate", bus.taken_cnt, 255);
        idle_inputs();
        halt_prog(2'd1);

        // Held start from DONE gives exactly one launch.
        launches = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (bus.jen) launches++;
        end
        bus.start = 1'b0;
        check("held_start_single_launch", launches, 1);

        // Reset mid-RUN with a taken branch pending.
        bus.br_req = 1'b1;
        bus.br_idx = 4'd5;
        tick();
        #1;
        check("pre_rst_jen", bus.jen, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_jen", bus.jen, 0);
        check("mid_rst_jump", bus.jump, 0);
        check("mid_rst_taken", bus.taken_cnt, 0);
        check("mid_rst_prog", bus.prog_num, 0);
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        launch(10'd0, 2'd0);
        bus.br_req = 1'b1;
        bus.br_idx = 4'd5;
        #1;
        check("lut_cleared_jen", bus.jen, 1);
        check("lut_cleared_jump", bus.jump, 0);
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
